silver_mem_ctrl: RTL and testbench

Memory-side controller sitting directly downstream of `processor_wrapper`. It consumes the processor's `command`/`data_addr`/`data_wdata`/`data_wstrb` requests and returns `ready`, `error`, `data_rdata` and `interrupt_ack`. It converts each request into one transaction on a single-outstanding valid/accept bus toward RAM/peripherals, with a timeout watchdog. It also latches the boot address and presents it as `mem_start`/`mem_start_ready`.

---
 rtl/silver_mem_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_silver_mem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/silver_mem_ctrl.sv
// Memory-side request controller: turns processor commands into single-outstanding
// valid/accept bus transactions or interrupt handshakes, with a timeout watchdog and boot latch.
module silver_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  command,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        ready,
  output logic [31:0] data_rdata,
  output logic [1:0]  error,
  output logic        interrupt_ack,
  output logic        mem_start_ready,
  output logic [31:0] mem_start,
  input  logic        boot_valid,
  input  logic [31:0] boot_addr,
  output logic        irq_req,
  input  logic        irq_done,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_accept,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_resp,
  output logic [1:0]  dbg_state
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_IRQ  = 2'd3;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_BUS   = 2'd1;
  localparam logic [1:0] ERR_TO    = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_IRQ  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic          mis_q, mis_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    error_q, error_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          irq_req_q, irq_req_d;
  logic          m_valid_q, m_valid_d;
  logic          m_we_q, m_we_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [3:0]    m_wstrb_q, m_wstrb_d;
  logic [31:0]   mem_start_q, mem_start_d;
  logic          boot_done_q, boot_done_d;

  logic          accept;
  logic          misaligned;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;

  // Handshake: m_valid rises on acceptance and stays up with m_* frozen until the
  // edge that samples m_accept; m_rvalid is honoured only while a transfer is open.
  assign accept      = (state_q == S_IDLE) && armed_q && (command != CMD_NONE);
  assign misaligned  = (data_addr[1:0] != 2'b00) &&
                       ((command == CMD_RD) || ((command == CMD_WR) && (data_wstrb == 4'hF)));
  assign cnt_inc     = cnt_q + CW'(1);
  assign timeout_hit = (cnt_inc == TO_LIMIT);

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    mis_d       = mis_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    irq_req_d   = irq_req_q;
    m_valid_d   = m_valid_q;
    m_we_d      = m_we_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    mem_start_d = mem_start_q;
    boot_done_d = boot_done_q;

    // A held command cannot re-fire; an idle command cycle re-arms.
    if (command == CMD_NONE) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          armed_d = 1'b0;
          error_d = ERR_OK;
          cnt_d   = '0;
          if (command == CMD_IRQ) begin
            irq_req_d = 1'b1;
            state_d   = S_IRQ;
          end else if (misaligned) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            m_valid_d = 1'b1;
            m_we_d    = (command == CMD_WR);
            m_addr_d  = {data_addr[31:2], 2'b00};
            m_wdata_d = data_wdata;
            m_wstrb_d = (command == CMD_WR) ? data_wstrb : 4'h0;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (m_accept && m_rvalid) begin
          m_valid_d = 1'b0;
          error_d   = m_resp ? ERR_BUS : ERR_OK;
          if (!m_we_q && !m_resp) begin
            rdata_d = m_rdata;
          end
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          m_valid_d = 1'b0;
          error_d   = ERR_TO;
          state_d   = S_IDLE;
        end else if (m_accept) begin
          m_valid_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_inc;
        if (mis_q) begin
          mis_d   = 1'b0;
          error_d = ERR_ALIGN;
          state_d = S_IDLE;
        end else if (m_rvalid) begin
          error_d = m_resp ? ERR_BUS : ERR_OK;
          if (!m_we_q && !m_resp) begin
            rdata_d = m_rdata;
          end
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          error_d = ERR_TO;
          state_d = S_IDLE;
        end
      end
      S_IRQ: begin
        cnt_d = cnt_inc;
        if (irq_done) begin
          irq_req_d = 1'b0;
          ack_d     = 1'b1;
          error_d   = ERR_OK;
          state_d   = S_IDLE;
        end else if (timeout_hit) begin
          irq_req_d = 1'b0;
          error_d   = ERR_TO;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Only the first boot strobe after reset counts.
    if (boot_valid && !boot_done_q) begin
      mem_start_d = boot_addr;
      boot_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b1;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
      error_q     <= ERR_OK;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      irq_req_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      mem_start_q <= '0;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      mis_q       <= mis_d;
      cnt_q       <= cnt_d;
      error_q     <= error_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      irq_req_q   <= irq_req_d;
      m_valid_q   <= m_valid_d;
      m_we_q      <= m_we_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      mem_start_q <= mem_start_d;
      boot_done_q <= boot_done_d;
    end
  end

  assign ready           = (state_q == S_IDLE);
  assign data_rdata      = rdata_q;
  assign error           = error_q;
  assign interrupt_ack   = ack_q;
  assign irq_req         = irq_req_q;
  assign m_valid         = m_valid_q;
  assign m_we            = m_we_q;
  assign m_addr          = m_addr_q;
  assign m_wdata         = m_wdata_q;
  assign m_wstrb         = m_wstrb_q;
  assign mem_start       = mem_start_q;
  assign mem_start_ready = boot_done_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_silver_mem_ctrl.sv
// Directed bench for silver_mem_ctrl: transaction-level result model feeding an
// expected queue, a per-cycle idle compare process, and literal spot checks.
module tb_silver_mem_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  command;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        ready;
  logic [31:0] data_rdata;
  logic [1:0]  error;
  logic        interrupt_ack, mem_start_ready;
  logic [31:0] mem_start;
  logic        boot_valid;
  logic [31:0] boot_addr;
  logic        irq_req, irq_done;
  logic        m_valid, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_accept, m_rvalid;
  logic [31:0] m_rdata;
  logic        m_resp;
  logic [1:0]  dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int n_bus_req = 0;
  logic prev_valid = 1'b0;

  // Model state: {error, data_rdata} expected whenever the controller is idle.
  logic [33:0] exp_q[$];
  logic [1:0]  mdl_error;
  logic [31:0] mdl_rdata;
  logic        busy = 1'b1;
  logic        cmp_en = 1'b0;
  logic        exp_ack = 1'b0;
  logic [31:0] exp_ms = '0;
  logic        exp_msr = 1'b0;

  silver_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .command(command), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .ready(ready),
    .data_rdata(data_rdata), .error(error), .interrupt_ack(interrupt_ack),
    .mem_start_ready(mem_start_ready), .mem_start(mem_start),
    .boot_valid(boot_valid), .boot_addr(boot_addr), .irq_req(irq_req),
    .irq_done(irq_done), .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_accept(m_accept),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_resp(m_resp),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_rdata"}, data_rdata, 0);
    chk({tag, "_ack"}, interrupt_ack, 0);
    chk({tag, "_irq_req"}, irq_req, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_wstrb"}, m_wstrb, 0);
    chk({tag, "_mem_start"}, mem_start, 0);
    chk({tag, "_mem_start_ready"}, mem_start_ready, 0);
  endtask

  // Result rules of a completed request, independent of cycle timing.
  task automatic model_complete(input logic [1:0] cmd, input logic [31:0] addr,
                                input logic [3:0] wstrb, input logic resp,
                                input logic [31:0] rdata);
    if (cmd != 2'd3 && addr[1:0] != 2'b00 && (cmd == 2'd1 || wstrb == 4'hF)) begin
      mdl_error = 2'd3;
    end else if (cmd == 2'd3) begin
      mdl_error = 2'd0;
    end else if (resp) begin
      mdl_error = 2'd1;
    end else begin
      mdl_error = 2'd0;
      if (cmd == 2'd1) mdl_rdata = rdata;
    end
    exp_q.push_back({mdl_error, mdl_rdata});
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en && rstn) begin
      if (!busy && exp_q.size() > 0) begin
        if (exp_q.size() > 1) void'(exp_q.pop_front());
        chk("idle_ready", ready, 1);
        chk("idle_error", error, exp_q[0][33:32]);
        chk("idle_rdata", data_rdata, exp_q[0][31:0]);
        chk("idle_m_valid", m_valid, 0);
        chk("idle_irq_req", irq_req, 0);
      end
      chk("cyc_interrupt_ack", interrupt_ack, exp_ack);
      chk("cyc_mem_start", mem_start, exp_ms);
      chk("cyc_mem_start_ready", mem_start_ready, exp_msr);
    end
  end

  always @(posedge clk) begin
    prev_valid <= m_valid;
    if (m_valid && !prev_valid) n_bus_req <= n_bus_req + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rw(input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input int acc_wait, input int rsp_wait,
                       input logic [31:0] rdata, input logic resp, input bit hold);
    logic [31:0] baddr;
    baddr = {addr[31:2], 2'b00};
    busy = 1'b1;
    command = cmd; data_addr = addr; data_wdata = wdata; data_wstrb = wstrb;
    tick;
    chk("acc_ready", ready, 0);
    chk("acc_err_clr", error, 0);
    chk("acc_m_valid", m_valid, 1);
    chk("acc_m_addr", m_addr, baddr);
    chk("acc_m_we", m_we, (cmd == 2'd2));
    chk("acc_m_wstrb", m_wstrb, (cmd == 2'd2) ? wstrb : 4'h0);
    if (cmd == 2'd2) chk("acc_m_wdata", m_wdata, wdata);
    if (!hold) command = 2'd0;
    repeat (acc_wait) begin
      tick;
      chk("req_hold_valid", m_valid, 1);
      chk("req_hold_addr", m_addr, baddr);
      chk("req_ready", ready, 0);
    end
    m_accept = 1'b1;
    if (rsp_wait == 0) begin
      m_rvalid = 1'b1; m_rdata = rdata; m_resp = resp;
    end
    tick;
    m_accept = 1'b0; m_rvalid = 1'b0;
    if (rsp_wait > 0) begin
      chk("resp_m_valid_drop", m_valid, 0);
      chk("resp_ready", ready, 0);
      repeat (rsp_wait - 1) begin
        tick;
        chk("resp_wait_ready", ready, 0);
      end
      m_rvalid = 1'b1; m_rdata = rdata; m_resp = resp;
      tick;
      m_rvalid = 1'b0;
    end
    m_resp = 1'b0; m_rdata = '0;
    model_complete(cmd, addr, wstrb, resp, rdata);
    busy = 1'b0;
  endtask

  task automatic do_mis(input logic [31:0] addr);
    busy = 1'b1;
    command = 2'd1; data_addr = addr;
    tick;
    chk("mis_ready_low", ready, 0);
    chk("mis_no_m_valid", m_valid, 0);
    command = 2'd0;
    tick;
    model_complete(2'd1, addr, 4'h0, 1'b0, 32'h0);
    busy = 1'b0;
    chk("mis_err_lit", error, 3);
  endtask

  task automatic do_timeout_write(input logic [31:0] addr, input logic [31:0] wdata);
    busy = 1'b1;
    command = 2'd2; data_addr = addr; data_wdata = wdata; data_wstrb = 4'hF;
    tick;
    chk("to_acc_valid", m_valid, 1);
    command = 2'd0;
    for (int i = 1; i < TO; i++) begin
      tick;
      chk("to_wait_valid", m_valid, 1);
      chk("to_wait_ready", ready, 0);
    end
    tick;
    mdl_error = 2'd2;
    exp_q.push_back({mdl_error, mdl_rdata});
    busy = 1'b0;
    chk("to_err_lit", error, 2);
    chk("to_m_valid_drop", m_valid, 0);
    m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
    tick;
    m_rvalid = 1'b0; m_rdata = '0;
    chk("late_rvalid_ready", ready, 1);
  endtask

  task automatic do_irq(input int done_after);
    busy = 1'b1;
    command = 2'd3;
    tick;
    chk("irq_acc_req", irq_req, 1);
    chk("irq_acc_ready", ready, 0);
    chk("irq_no_m_valid", m_valid, 0);
    command = 2'd0;
    repeat (done_after - 1) begin
      tick;
      chk("irq_wait_req", irq_req, 1);
      chk("irq_wait_ack", interrupt_ack, 0);
    end
    irq_done = 1'b1;
    tick;
    irq_done = 1'b0;
    model_complete(2'd3, 32'h0, 4'h0, 1'b0, 32'h0);
    exp_ack = 1'b1;
    busy = 1'b0;
    chk("irq_ack_lit", interrupt_ack, 1);
    chk("irq_req_drop", irq_req, 0);
    tick;
    exp_ack = 1'b0;
    chk("irq_ack_once", interrupt_ack, 0);
  endtask

  task automatic do_boot(input logic [31:0] addr);
    boot_valid = 1'b1; boot_addr = addr;
    tick;
    if (!exp_msr) begin
      exp_ms = addr;
      exp_msr = 1'b1;
    end
    boot_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    rstn = 1'b0;
    command = '0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    boot_valid = 1'b0; boot_addr = '0; irq_done = 1'b0;
    m_accept = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_resp = 1'b0;
    mdl_error = '0; mdl_rdata = '0;
    #12;
    chk_reset("rst");
    tick;
    rstn = 1'b1;
    exp_q.push_back(34'h0);
    busy = 1'b0;
    cmp_en = 1'b1;
    tick;

    do_boot(32'h0000_1000);
    tick;
    do_boot(32'h0000_2000);
    tick;
    chk("boot_mem_start_lit", mem_start, 32'h0000_1000);
    chk("boot_ready_lit", mem_start_ready, 1);

    do_rw(2'd1, 32'h40, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("rd_data_lit", data_rdata, 32'hDEADBEEF);
    chk("rd_err_lit", error, 0);
    tick;

    base = n_bus_req;
    do_rw(2'd2, 32'h44, 32'h12345678, 4'h3, 0, 0, 32'h0, 1'b0, 1'b1);
    repeat (3) tick;
    chk("held_one_write", n_bus_req - base, 1);
    command = 2'd0;
    tick;
    do_rw(2'd2, 32'h44, 32'h87654321, 4'hC, 0, 1, 32'h0, 1'b0, 1'b0);
    tick;
    chk("rearm_second_write", n_bus_req - base, 2);

    do_mis(32'h41);
    chk("mis_rdata_kept_lit", data_rdata, 32'hDEADBEEF);
    tick;

    do_rw(2'd1, 32'h80, 32'h0, 4'h0, 0, 2, 32'h5555_5555, 1'b1, 1'b0);
    chk("bus_err_lit", error, 1);
    chk("bus_err_rdata_lit", data_rdata, 32'hDEADBEEF);
    tick;

    do_timeout_write(32'h90, 32'hA5A5A5A5);
    tick;

    do_rw(2'd1, 32'h100, 32'h0, 4'h0, 0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
    chk("rd2_data_lit", data_rdata, 32'hCAFEF00D);
    tick;

    do_irq(3);
    tick;

    busy = 1'b1;
    command = 2'd3;
    tick;
    command = 2'd0;
    chk("irq2_req", irq_req, 1);
    tick;
    #2;
    rstn = 1'b0;
    #1;
    chk_reset("midrst");
    mdl_error = '0; mdl_rdata = '0;
    exp_ms = '0; exp_msr = 1'b0;
    exp_q.delete();
    exp_q.push_back(34'h0);
    busy = 1'b0;
    tick;
    rstn = 1'b1;
    repeat (3) tick;
    chk("post_rst_ready", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
